data_bus_responder: RTL and testbench
=====================================

# data_bus_responder

Data-bus responder for the pipelined CPU core: it decodes the CPU's data address, serves a word RAM and a small memory-mapped peripheral page (free-running cycle counter and a FIFO-buffered 8N1 serial transmitter), and returns read data in the same cycle. It sits at the top level between the CPU data-bus outputs and the board serial pin, and it replaces any bare data-memory model.

## Interface
- DATA_WIDTH, 32: data word width; matches the CPU data path.
- ADDR_WIDTH, 16: word address width; matches the CPU data address path.
- RAM_WORDS, 1024: RAM depth in words; RAM occupies addresses 0 .. RAM_WORDS-1.
- FIFO_DEPTH, 4: TX FIFO entries; a power of two, at least 2.
- CLKS_PER_BIT, 16: clock cycles per serial bit; at least 2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- dataAddr  in  ADDR_WIDTH  word address from the CPU.
- dataOut  in  DATA_WIDTH  write data from the CPU.
- dataWrEnable  in  1  write strobe; the write commits at the rising edge.
- dataIn  out  DATA_WIDTH  read data to the CPU; combinational from dataAddr and current state.
- txd  out  1  serial line; idles high.
- txBusy  out  1  high while the transmitter is not in IDLE or the FIFO is non-empty.

## Operation
- Address map (word addresses):
  - 0 .. RAM_WORDS-1: RAM.
  - 0xFF00: CNT, cycle counter, read/write.
  - 0xFF01: TXDATA. A write pushes dataOut[7:0]; a read returns 0.
  - 0xFF02: STATUS, read-only except bit3.
  - All other addresses: reads return 0 and writes are ignored.
- RAM:
  - Reads are asynchronous.
  - A write lands at the edge and is visible to a read in the following cycle.
  - RAM contents are not reset.
- CNT:
  - Increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
  - A CNT write loads dataOut at the edge; the write wins over the increment that cycle.
  - A read returns the pre-edge value.
- STATUS fields:
  - bit0: FIFO full.
  - bit1: FIFO empty.
  - bit2: transmitter not in IDLE.
  - bit3: sticky overflow.
  - bits[7:4]: FIFO occupancy.
  - All other bits read as 0.
- Overflow bit: a STATUS write with dataOut[3]=1 clears it. If overflow is set by a push in the same cycle as the clear, the set wins.
- TX FIFO:
  - A push when the pre-edge state is full is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
  - Push and pop in the same cycle with the FIFO not full: occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- TX state machine (states IDLE, START, DATA, STOP):
  - IDLE: txd=1. If the FIFO is non-empty (registered state), pop the head into the shift register and go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send 8 bits LSB first, each for CLKS_PER_BIT cycles; a 3-bit index counts the bits. After bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - The bit timer counts 0 .. CLKS_PER_BIT-1 and restarts on every state or bit change.

## Timing
- Reset values (all asynchronous on rst=1):
  - CNT=0.
  - FIFO empty, pointers 0, overflow=0.
  - State IDLE, bit timer 0.
  - txd=1, txBusy=0.
  - dataIn follows the decode: with reset state, CNT reads 0 and STATUS reads 0x2.
- Reset asserted mid-frame: txd returns to 1 immediately and all queued bytes are discarded.
- Read latency is 0 cycles: dataIn is valid in the same cycle that dataAddr is presented.
- Write latency to first txd fall: a TXDATA push at edge N, with the FIFO previously empty and the transmitter in IDLE, gives a pop at edge N+1 and txd=0 from edge N+1.
- Frame length is 10*CLKS_PER_BIT cycles.
- Back-to-back bytes have exactly one IDLE cycle between the end of STOP and the next START.
- txBusy is registered-state based; it rises at edge N (the push edge) in the case above.

## Test plan
- Reset values: assert rst mid-simulation -> txd=1, txBusy=0, STATUS read=0x2, CNT read=0. Release rst -> CNT reads 5 five cycles later.
- RAM round trip: write 0xDEADBEEF to address 3, then read address 3 the next cycle -> 0xDEADBEEF. A read of unmapped 0x8000 -> 0.
- CNT load and wrap: write 0xFFFFFFFE to CNT -> reads return 0xFFFFFFFE, then 0xFFFFFFFF, then 0x00000000 on successive cycles.
- Serial frame: CLKS_PER_BIT=4, push 0xA5 -> txd falls one cycle after the push edge. Bits sampled mid-bit give 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). The frame lasts 40 cycles.
- FIFO overflow: with FIFO_DEPTH=4, push 6 bytes in consecutive cycles while the first frame is active. Expected:
  - The first byte is popped one cycle after its push, so the remaining pushes fill the FIFO (STATUS bit0=1, occupancy 4).
  - The sixth push is dropped and sets bit3.
  - Exactly 5 frames are sent.
  - Writing STATUS with 0x8 clears bit3.
- Simultaneous push and pop: push a byte exactly on the IDLE pop edge with occupancy 1 -> occupancy stays 1, and both bytes are transmitted in order.

Source files
------------

// File: rtl/data_bus_responder.sv
// Data-bus responder: word RAM plus a memory-mapped peripheral page holding a
// free-running cycle counter and a FIFO-buffered 8N1 serial transmitter.
module data_bus_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int RAM_WORDS    = 1024,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dataAddr,
  input  logic [DATA_WIDTH-1:0] dataOut,
  input  logic                  dataWrEnable,
  output logic [DATA_WIDTH-1:0] dataIn,
  output logic                  txd,
  output logic                  txBusy
);

  localparam int RAM_IDX_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int COUNT_W   = PTR_W + 1;
  localparam int TIMER_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [ADDR_WIDTH:0]   RAM_LIMIT   = (ADDR_WIDTH+1)'(RAM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] CNT_ADDR    = ADDR_WIDTH'('hFF00);
  localparam logic [ADDR_WIDTH-1:0] TXDATA_ADDR = ADDR_WIDTH'('hFF01);
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'('hFF02);
  localparam logic [COUNT_W-1:0]    FIFO_FULL   = COUNT_W'(FIFO_DEPTH);
  localparam logic [TIMER_W-1:0]    TIMER_LAST  = TIMER_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txStateT;

  // Address decode
  logic                 isRam, isCnt, isTxData, isStatus;
  logic [RAM_IDX_W-1:0] ramIdx;

  assign isRam    = {1'b0, dataAddr} < RAM_LIMIT;
  assign isCnt    = dataAddr == CNT_ADDR;
  assign isTxData = dataAddr == TXDATA_ADDR;
  assign isStatus = dataAddr == STATUS_ADDR;
  assign ramIdx   = dataAddr[RAM_IDX_W-1:0];

  // State
  logic [DATA_WIDTH-1:0] ram [RAM_WORDS];
  logic [DATA_WIDTH-1:0] cnt;
  logic [7:0]            fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wrPtr, rdPtr;
  logic [COUNT_W-1:0]    fifoCount;
  logic                  overflow;
  txStateT               txState;
  logic [TIMER_W-1:0]    bitTimer;
  logic [2:0]            bitIdx;
  logic [7:0]            shiftReg;

  logic fifoFull, fifoEmpty, push, pushOk, pushDrop, pop, ovfClear, bitDone;
  logic [7:0] statusByte;

  assign fifoFull  = fifoCount == FIFO_FULL;
  assign fifoEmpty = fifoCount == '0;
  assign push      = dataWrEnable && isTxData;
  assign pushOk    = push && !fifoFull;
  assign pushDrop  = push && fifoFull;
  assign pop       = (txState == IDLE) && !fifoEmpty;
  assign ovfClear  = dataWrEnable && isStatus && dataOut[3];
  assign bitDone   = bitTimer == TIMER_LAST;
  assign txBusy    = (txState != IDLE) || !fifoEmpty;

  assign statusByte = {4'(fifoCount), overflow, txState != IDLE, fifoEmpty, fifoFull};

  // NOTE: arrays are left unreset so they map onto plain RAM macros; only
  // control state carries a reset value.
  always_ff @(posedge clk) begin
    if (dataWrEnable && isRam) ram[ramIdx] <= dataOut;
  end

  always_ff @(posedge clk) begin
    if (pushOk) fifoMem[wrPtr] <= dataOut[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (dataWrEnable && isCnt) begin
      cnt <= dataOut;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
      overflow  <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
      case ({pushOk, pop})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
      if (pushDrop)      overflow <= 1'b1;
      else if (ovfClear) overflow <= 1'b0;
    end
  end

  // Transmitter: txd is registered and changes on the edge that enters each bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txState  <= IDLE;
      bitTimer <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txd      <= 1'b1;
    end else begin
      case (txState)
        IDLE: begin
          txd      <= 1'b1;
          bitTimer <= '0;
          if (!fifoEmpty) begin
            shiftReg <= fifoMem[rdPtr];
            txd      <= 1'b0;
            txState  <= START;
          end
        end
        START: begin
          if (bitDone) begin
            bitTimer <= '0;
            bitIdx   <= '0;
            txd      <= shiftReg[0];
            shiftReg <= {1'b0, shiftReg[7:1]};
            txState  <= DATA;
          end else begin
            bitTimer <= bitTimer + 1'b1;
          end
        end
        DATA: begin
          if (bitDone) begin
            bitTimer <= '0;
            if (bitIdx == 3'd7) begin
              txd     <= 1'b1;
              txState <= STOP;
            end else begin
              bitIdx   <= bitIdx + 3'd1;
              txd      <= shiftReg[0];
              shiftReg <= {1'b0, shiftReg[7:1]};
            end
          end else begin
            bitTimer <= bitTimer + 1'b1;
          end
        end
        STOP: begin
          if (bitDone) begin
            bitTimer <= '0;
            txState  <= IDLE;
          end else begin
            bitTimer <= bitTimer + 1'b1;
          end
        end
        default: txState <= IDLE;
      endcase
    end
  end

  // NOTE: the default assignment first keeps this combinational block from
  // inferring a latch on any undecoded address.
  always_comb begin
    dataIn = '0;
    if (isRam)         dataIn = ram[ramIdx];
    else if (isCnt)    dataIn = cnt;
    else if (isStatus) dataIn = DATA_WIDTH'(statusByte);
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: bus decode, counter, RAM, and the
// serial transmitter observed through a bit-level receiver on txd.
module tb_data_bus_responder;

  localparam int CPB = 4;

  localparam logic [15:0] CNT_A    = 16'hFF00;
  localparam logic [15:0] TXDATA_A = 16'hFF01;
  localparam logic [15:0] STATUS_A = 16'hFF02;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dataAddr;
  logic [31:0] dataOut;
  logic        dataWrEnable;
  logic [31:0] dataIn;
  logic        txd;
  logic        txBusy;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0] rxQ [$];
  logic       rxEnable;
  logic       sawLow;

  data_bus_responder #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (16),
    .RAM_WORDS   (1024),
    .FIFO_DEPTH  (4),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dataAddr    (dataAddr),
    .dataOut     (dataOut),
    .dataWrEnable(dataWrEnable),
    .dataIn      (dataIn),
    .txd         (txd),
    .txBusy      (txBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [15:0] addr, input logic [31:0] data);
    dataAddr     = addr;
    dataOut      = data;
    dataWrEnable = 1'b1;
    step();
    dataWrEnable = 1'b0;
  endtask

  task automatic busRead(input logic [15:0] addr, input logic [31:0] exp, input string tag);
    dataAddr = addr;
    #1;
    check(tag, dataIn, exp);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (txBusy && n < 2000) begin
      step();
      n++;
    end
    check(tag, 32'(txBusy), 32'd0);
  endtask

  // Bit-level receiver: mid-bit sampling of every frame on txd.
  initial begin : rxMon
    logic [7:0] rxByte;
    forever begin
      @(negedge clk);
      if (rxEnable && !rst && txd == 1'b0) begin
        repeat (CPB/2) @(negedge clk);
        check("rx_start_bit", 32'(txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rxByte[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        check("rx_stop_bit", 32'(txd), 32'd1);
        rxQ.push_back(rxByte);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] frameBits [10];
    rst          = 1'b1;
    dataAddr     = '0;
    dataOut      = '0;
    dataWrEnable = 1'b0;
    rxEnable     = 1'b1;
    frameBits    = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1};

    // Reset state
    step();
    step();
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_txbusy", 32'(txBusy), 32'd0);
    busRead(STATUS_A, 32'h2, "rst_status");
    busRead(CNT_A, 32'h0, "rst_cnt");
    rst = 1'b0;
    repeat (5) step();
    busRead(CNT_A, 32'd5, "cnt_after_release");

    // RAM, boundaries and unmapped space
    busWrite(16'd0, 32'h1111_1111);
    busWrite(16'd1023, 32'hCAFE_F00D);
    busWrite(16'd1024, 32'h2222_2222);
    busWrite(16'hFF03, 32'h3333_3333);
    busWrite(16'd3, 32'hDEAD_BEEF);
    busRead(16'd3, 32'hDEAD_BEEF, "ram_addr3");
    busRead(16'd1023, 32'hCAFE_F00D, "ram_top");
    busRead(16'd0, 32'h1111_1111, "ram_no_alias");
    busRead(16'd1024, 32'h0, "ram_past_end");
    busRead(16'h8000, 32'h0, "unmapped_8000");
    busRead(16'hFF03, 32'h0, "unmapped_ff03");
    busRead(TXDATA_A, 32'h0, "txdata_read");

    // Counter load and wrap
    busWrite(CNT_A, 32'hFFFF_FFFE);
    busRead(CNT_A, 32'hFFFF_FFFE, "cnt_load");
    step();
    busRead(CNT_A, 32'hFFFF_FFFF, "cnt_max");
    step();
    busRead(CNT_A, 32'h0, "cnt_wrap");

    // Single frame 0xA5
    busWrite(TXDATA_A, 32'hA5);
    check("push_txd_high", 32'(txd), 32'd1);
    check("push_txbusy", 32'(txBusy), 32'd1);
    busRead(STATUS_A, 32'h10, "push_status");
    step();
    check("pop_txd_low", 32'(txd), 32'd0);
    busRead(STATUS_A, 32'h6, "pop_status");
    step();
    step();
    check("frame_bit0", 32'(txd), 32'(frameBits[0]));
    for (int i = 1; i < 10; i++) begin
      repeat (CPB) step();
      check($sformatf("frame_bit%0d", i), 32'(txd), 32'(frameBits[i]));
    end
    step();
    check("frame_last_cycle_busy", 32'(txBusy), 32'd1);
    step();
    check("frame_end_idle", 32'(txBusy), 32'd0);
    check("frame_end_txd", 32'(txd), 32'd1);
    check("rx_single_count", 32'(rxQ.size()), 32'd1);
    check("rx_single_byte", 32'(rxQ[0]), 32'hA5);
    rxQ.delete();

    // Overflow: six pushes back to back
    for (int i = 0; i < 6; i++) begin
      busWrite(TXDATA_A, 32'h11 + i);
      if (i == 4) busRead(STATUS_A, 32'h45, "ovf_fifo_full");
    end
    busRead(STATUS_A, 32'h4D, "ovf_sticky_set");
    busWrite(STATUS_A, 32'h8);
    busRead(STATUS_A, 32'h45, "ovf_cleared");
    waitIdle("ovf_drain_timeout");
    check("ovf_frame_count", 32'(rxQ.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("ovf_byte%0d", i), 32'(rxQ[i]), 32'h11 + i);
    rxQ.delete();

    // Push on the IDLE pop edge with occupancy 1
    busWrite(TXDATA_A, 32'h3C);
    busWrite(TXDATA_A, 32'hC3);
    busRead(STATUS_A, 32'h14, "pushpop_status");
    waitIdle("pushpop_drain_timeout");
    check("pushpop_count", 32'(rxQ.size()), 32'd2);
    check("pushpop_first", 32'(rxQ[0]), 32'h3C);
    check("pushpop_second", 32'(rxQ[1]), 32'hC3);

    // Reset mid-frame with bytes still queued
    rxEnable = 1'b0;
    busWrite(TXDATA_A, 32'h5A);
    busWrite(TXDATA_A, 32'h77);
    busWrite(TXDATA_A, 32'h99);
    repeat (10) step();
    rst = 1'b1;
    #1;
    check("midrst_txd", 32'(txd), 32'd1);
    check("midrst_txbusy", 32'(txBusy), 32'd0);
    busRead(STATUS_A, 32'h2, "midrst_status");
    busRead(CNT_A, 32'h0, "midrst_cnt");
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();
    busRead(CNT_A, 32'd5, "midrst_cnt_release");
    sawLow = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (txd == 1'b0) sawLow = 1'b1;
    end
    check("midrst_queue_discarded", 32'(sawLow), 32'd0);
    busRead(STATUS_A, 32'h2, "midrst_status_after");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
